// File: rtl/cgra_pkg.sv
// Shared PE frame layout, opcodes and sequencer state encoding.
// Optional ACC_CLR preamble is enabled with `define CGRA_SEQ_ACC_CLR_EN.
package cgra_pkg;

    localparam int PE_FRAME_W = 64;

    // Frame field offsets (PE frame format)
    localparam int OPC_LSB   = 0;
    localparam int OPC_W     = 4;
    localparam int SRC_A_LSB = 4;
    localparam int SRC_B_LSB = 8;
    localparam int DST_LSB   = 12;
    localparam int IMM_LSB   = 16;

    localparam logic [OPC_W-1:0] OP_NOP     = 4'd0;
    localparam logic [OPC_W-1:0] OP_ADD     = 4'd1;
    localparam logic [OPC_W-1:0] OP_SUB     = 4'd2;
    localparam logic [OPC_W-1:0] OP_MUL     = 4'd3;
    localparam logic [OPC_W-1:0] OP_MAC     = 4'd4;
    localparam logic [OPC_W-1:0] OP_ACC_CLR = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        RUN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/cgra_ctx_mem.sv
// Context store: DEPTH x W flop array, one write port, one async read port.
// No reset; contents are defined only by loader writes.
module cgra_ctx_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 64
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cgra_ctx_sequencer.sv
// Per-PE context sequencer: replays contexts 0..ii-1 for iter_count iterations.
// `define CGRA_SEQ_ACC_CLR_EN adds an ACC_CLR preamble frame (PRE state).
module cgra_ctx_sequencer
    import cgra_pkg::*;
#(
    parameter int CTX_DEPTH = 16,
    parameter int CTX_AW    = $clog2(CTX_DEPTH),
    parameter int FRAME_W   = PE_FRAME_W,
    parameter int ITER_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [CTX_AW-1:0]  ld_addr,
    input  logic [FRAME_W-1:0] ld_frame,
    input  logic               start,
    input  logic [CTX_AW:0]    ii,
    input  logic [ITER_W-1:0]  iter_count,
    input  logic               stall,
    output logic [FRAME_W-1:0] config_frame,
    output logic               config_valid,
    output logic [CTX_AW-1:0]  ctx_idx,
    output logic [ITER_W-1:0]  iter_idx,
    output logic               busy,
    output logic               done
);

    localparam logic [CTX_AW:0] DEPTH_V = (CTX_AW+1)'(CTX_DEPTH);

`ifdef CGRA_SEQ_ACC_CLR_EN
    localparam logic [FRAME_W-1:0] PRE_FRAME =
        FRAME_W'(OP_ACC_CLR) << OPC_LSB;
`endif

    seq_state_t state, state_nxt;

    logic [CTX_AW-1:0]  ptr, ptr_cur, ptr_nxt;
    logic [ITER_W-1:0]  itr, itr_cur, itr_nxt;
    logic [CTX_AW:0]    ii_r, ii_clamp, ii_cur;
    logic [ITER_W-1:0]  iter_r;
    logic [CTX_AW-1:0]  rd_addr;
    logic [FRAME_W-1:0] mem_rdata, rd_frame;
    logic               ld_fire, start_acc, zero_len, wrap, all_issued;
    logic               do_issue, do_pre;

    assign ld_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign ld_fire   = ld_valid & ld_ready;
    assign start_acc = start & (state == IDLE);
    assign ii_clamp  = (ii > DEPTH_V) ? DEPTH_V : ii;
    assign zero_len  = (ii_clamp == '0) || (iter_count == '0);

    // In IDLE the counters are treated as already cleared for the start edge
    assign ii_cur     = (state == IDLE) ? ii_clamp : ii_r;
    assign ptr_cur    = (state == IDLE) ? '0 : ptr;
    assign itr_cur    = (state == IDLE) ? '0 : itr;
    assign wrap       = ({1'b0, ptr_cur} == (ii_cur - 1'b1));
    assign ptr_nxt    = wrap ? '0 : ptr_cur + 1'b1;
    assign itr_nxt    = wrap ? itr_cur + 1'b1 : itr_cur;
    assign all_issued = (itr == iter_r);

    assign rd_addr = ptr_cur;

    cgra_ctx_mem #(
        .DEPTH (CTX_DEPTH),
        .AW    (CTX_AW),
        .W     (FRAME_W)
    ) u_mem (
        .clk   (clk),
        .we    (ld_fire),
        .waddr (ld_addr),
        .wdata (ld_frame),
        .raddr (rd_addr),
        .rdata (mem_rdata)
    );

    // Same-cycle write to the slot being read is forwarded
    assign rd_frame = (ld_fire && ld_addr == rd_addr) ? ld_frame : mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_issue  = 1'b0;
        do_pre    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (zero_len) begin
                        state_nxt = DONE;
                    end else begin
`ifdef CGRA_SEQ_ACC_CLR_EN
                        state_nxt = PRE;
                        do_pre    = 1'b1;
`else
                        state_nxt = RUN;
                        do_issue  = 1'b1;
`endif
                    end
                end
            end
            PRE: begin
                if (!stall) begin
                    state_nxt = RUN;
                    do_issue  = 1'b1;
                end
            end
            RUN: begin
                if (all_issued) begin
                    state_nxt = DONE;
                end else if (!stall) begin
                    do_issue = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            config_frame <= '0;
            config_valid <= 1'b0;
            ctx_idx      <= '0;
            iter_idx     <= '0;
            ptr          <= '0;
            itr          <= '0;
            ii_r         <= '0;
            iter_r       <= '0;
        end else begin
            config_valid <= do_issue | do_pre;
            if (start_acc) begin
                ii_r   <= ii_clamp;
                iter_r <= iter_count;
                ptr    <= '0;
                itr    <= '0;
            end
`ifdef CGRA_SEQ_ACC_CLR_EN
            if (do_pre) begin
                config_frame <= PRE_FRAME;
                ctx_idx      <= '0;
                iter_idx     <= '0;
            end
`endif
            if (do_issue) begin
                config_frame <= rd_frame;
                ctx_idx      <= ptr_cur;
                iter_idx     <= itr_cur;
                ptr          <= ptr_nxt;
                itr          <= itr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cgra_ctx_sequencer.sv
// Directed self-checking bench for cgra_ctx_sequencer.
// Expected sequences are hand-derived cycle by cycle relative to start.
module tb_cgra_ctx_sequencer;

    logic        clk;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  ld_addr;
    logic [63:0] ld_frame;
    logic        start;
    logic [4:0]  ii;
    logic [15:0] iter_count;
    logic        stall;
    logic [63:0] config_frame;
    logic        config_valid;
    logic [3:0]  ctx_idx;
    logic [15:0] iter_idx;
    logic        busy;
    logic        done;

`ifdef CGRA_SEQ_ACC_CLR_EN
    localparam bit HAS_PRE = 1'b1;
`else
    localparam bit HAS_PRE = 1'b0;
`endif

    localparam logic [63:0] FA = 64'hAAAA_0000_1111_00A1;
    localparam logic [63:0] FB = 64'hBBBB_0000_2222_00B2;
    localparam logic [63:0] FC = 64'hCCCC_0000_3333_00C3;
    localparam logic [63:0] FX = 64'hDEAD_BEEF_0BAD_F00D;
    localparam logic [63:0] FPRE = 64'h0000_0000_0000_000F;

    int n_chk;
    int n_pass;

    cgra_ctx_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_frame     (ld_frame),
        .start        (start),
        .ii           (ii),
        .iter_count   (iter_count),
        .stall        (stall),
        .config_frame (config_frame),
        .config_valid (config_valid),
        .ctx_idx      (ctx_idx),
        .iter_idx     (iter_idx),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic exp_frame(input string tag, input logic [63:0] f,
                             input int c, input int i);
        chk({tag, ".valid"}, 64'(config_valid), 64'd1);
        chk({tag, ".frame"}, config_frame, f);
        chk({tag, ".ctx"},   64'(ctx_idx), 64'(c));
        chk({tag, ".iter"},  64'(iter_idx), 64'(i));
        chk({tag, ".busy"},  64'(busy), 64'd1);
        chk({tag, ".done"},  64'(done), 64'd0);
    endtask

    task automatic exp_quiet(input string tag, input bit b, input bit d);
        chk({tag, ".valid"}, 64'(config_valid), 64'd0);
        chk({tag, ".busy"},  64'(busy), 64'(b));
        chk({tag, ".done"},  64'(done), 64'(d));
    endtask

    task automatic load(input logic [3:0] a, input logic [63:0] f);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_frame = f;
        chk("load.ready", 64'(ld_ready), 64'd1);
        step();
        ld_valid = 1'b0;
    endtask

    // Leaves the bench in the cycle showing the first ctx[0] frame
    task automatic start_run(input string tag, input logic [4:0] n_ii,
                             input logic [15:0] n_it);
        start      = 1'b1;
        ii         = n_ii;
        iter_count = n_it;
        step();
        start = 1'b0;
        if (HAS_PRE) begin
            exp_frame({tag, ".pre"}, FPRE, 0, 0);
            step();
        end
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        ld_valid   = 1'b0;
        ld_addr    = '0;
        ld_frame   = '0;
        start      = 1'b0;
        ii         = '0;
        iter_count = '0;
        stall      = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst.valid", 64'(config_valid), 64'd0);
        chk("rst.frame", config_frame, 64'd0);
        chk("rst.ctx",   64'(ctx_idx), 64'd0);
        chk("rst.iter",  64'(iter_idx), 64'd0);
        chk("rst.busy",  64'(busy), 64'd0);
        chk("rst.done",  64'(done), 64'd0);
        chk("rst.ready", 64'(ld_ready), 64'd1);

        // 1: ii=3 iter=2
        load(4'd0, FA);
        load(4'd1, FB);
        load(4'd2, FC);
        start_run("t1", 5'd3, 16'd2);
        exp_frame("t1.f0", FA, 0, 0); step();
        exp_frame("t1.f1", FB, 1, 0); step();
        exp_frame("t1.f2", FC, 2, 0); step();
        exp_frame("t1.f3", FA, 0, 1); step();
        exp_frame("t1.f4", FB, 1, 1); step();
        exp_frame("t1.f5", FC, 2, 1); step();
        exp_quiet("t1.done", 1'b1, 1'b1); step();
        exp_quiet("t1.idle", 1'b0, 1'b0);

        // 2: ii=2 iter=3 with two stalled edges
        start_run("t2", 5'd2, 16'd3);
        exp_frame("t2.f0", FA, 0, 0); step();
        exp_frame("t2.f1", FB, 1, 0);
        stall = 1'b1;
        step();
        exp_quiet("t2.s0", 1'b1, 1'b0);
        chk("t2.s0.hold", config_frame, FB);
        chk("t2.s0.ctx", 64'(ctx_idx), 64'd1);
        step();
        exp_quiet("t2.s1", 1'b1, 1'b0);
        stall = 1'b0;
        step();
        exp_frame("t2.f2", FA, 0, 1); step();
        exp_frame("t2.f3", FB, 1, 1); step();
        exp_frame("t2.f4", FA, 0, 2); step();
        exp_frame("t2.f5", FB, 1, 2); step();
        exp_quiet("t2.done", 1'b1, 1'b1); step();
        exp_quiet("t2.idle", 1'b0, 1'b0);

        // 3: zero-length run
        start      = 1'b1;
        ii         = 5'd2;
        iter_count = 16'd0;
        step();
        start = 1'b0;
        exp_quiet("t3.done", 1'b1, 1'b1); step();
        exp_quiet("t3.idle", 1'b0, 1'b0);

        // 4: loads and start ignored while busy
        start_run("t4", 5'd1, 16'd3);
        exp_frame("t4.f0", FA, 0, 0);
        ld_valid   = 1'b1;
        ld_addr    = 4'd0;
        ld_frame   = FX;
        start      = 1'b1;
        ii         = 5'd2;
        iter_count = 16'd5;
        chk("t4.ready", 64'(ld_ready), 64'd0);
        step();
        exp_frame("t4.f1", FA, 0, 1);
        chk("t4.ready2", 64'(ld_ready), 64'd0);
        step();
        ld_valid = 1'b0;
        start    = 1'b0;
        exp_frame("t4.f2", FA, 0, 2); step();
        exp_quiet("t4.done", 1'b1, 1'b1); step();
        exp_quiet("t4.idle", 1'b0, 1'b0);
        start_run("t4r", 5'd1, 16'd1);
        exp_frame("t4r.f0", FA, 0, 0); step();
        exp_quiet("t4r.done", 1'b1, 1'b1); step();

        // 5: reset mid-run
        start_run("t5", 5'd3, 16'd2);
        exp_frame("t5.f0", FA, 0, 0); step();
        exp_frame("t5.f1", FB, 1, 0);
        rst_n = 1'b0;
        step();
        exp_quiet("t5.rst", 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        exp_quiet("t5.post", 1'b0, 1'b0);
        start_run("t5r", 5'd2, 16'd1);
        exp_frame("t5r.f0", FA, 0, 0); step();
        exp_frame("t5r.f1", FB, 1, 0); step();
        exp_quiet("t5r.done", 1'b1, 1'b1); step();
        exp_quiet("t5r.idle", 1'b0, 1'b0);

        // ii above depth clamps to 16 slots: slot 15 then wrap into iter 1
        start_run("t7", 5'd20, 16'd2);
        exp_frame("t7.f0", FA, 0, 0);
        for (int k = 1; k < 16; k++) step();
        chk("t7.ctx15", 64'(ctx_idx), 64'd15);
        chk("t7.it15", 64'(iter_idx), 64'd0);
        step();
        exp_frame("t7.wrap", FA, 0, 1);
        for (int k = 0; k < 16; k++) step();
        exp_quiet("t7.done", 1'b1, 1'b1); step();

`ifdef CGRA_SEQ_ACC_CLR_EN
        // 6: preamble then single frame
        start      = 1'b1;
        ii         = 5'd1;
        iter_count = 16'd1;
        step();
        start = 1'b0;
        exp_frame("t6.pre", FPRE, 0, 0); step();
        exp_frame("t6.f0", FA, 0, 0); step();
        exp_quiet("t6.done", 1'b1, 1'b1); step();
        exp_quiet("t6.idle", 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
